nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
// - Sequencer that reuses one 4-bit ripple-carry slice to add/subtract WIDTH-bit operands, one nibble per clock.
// - Trades latency for area; sits between an operand producer and a result consumer.
// - Uses a valid/ready handshake on both sides.
// - Holds one operation in flight; no overlap between operations.
// PARAMETERS
// - WIDTH    16  operand/result width; must be a multiple of 4 and >= 8.
// - NIBBLES  WIDTH/4  (localparam) slice passes per operation.
// PORTS
// - clk          in   1      single clock, rising edge.
// - rst_n        in   1      asynchronous, active-low reset.
// - flush        in   1      synchronous abort; returns the block to IDLE.
// - start_valid  in   1      operands valid.
// - start_ready  out  1      block can accept operands.
// - op_sub       in   1      0: a+b+c_in; 1: a-b-c_in (c_in is borrow-in).
// - a_in         in   WIDTH  operand A.
// - b_in         in   WIDTH  operand B.
// - c_in         in   1      carry-in (add) or borrow-in (sub).
// - res_valid    out  1      result valid.
// - res_ready    in   1      consumer accepts the result.
// - sum          out  WIDTH  result.
// - carry        out  1      carry-out (add) or NOT-borrow (sub).
// - overflow     out  1      signed overflow: carry into MSB XOR carry out of MSB.
// BEHAVIOUR
// - Reset: state=IDLE; sum=0, carry=0, overflow=0, res_valid=0; all operand/index/carry registers=0.
// - start_ready is 1 out of reset (it is 1 whenever state=IDLE).
// - FSM: IDLE -> RUN -> DONE -> IDLE.
// - start_ready = (state==IDLE); res_valid = (state==DONE). Both are decoded directly from the state register.
// - IDLE -> RUN on start_valid && start_ready. Same edge:
//   - latch a_in;
//   - latch b_in, or ~b_in when op_sub=1;
//   - latch op_sub;
//   - idx=0;
//   - carry_reg = c_in when op_sub=0, ~c_in when op_sub=1.
// - RUN, each cycle:
//   - slice inputs are nibble idx of A, nibble idx of B', and carry_reg;
//   - slice sum is written to result nibble idx; slice carry-out goes to carry_reg;
//   - idx increments.
//   - At idx==NIBBLES-1, record the carry into the MSB (from the MSB slice's internal bit-3 carry) and go to DONE.
// - Latency: res_valid rises exactly NIBBLES edges after the accepting edge (4 for WIDTH=16).
// - DONE: sum, carry and overflow are held stable while res_valid=1 && res_ready=0.
// - DONE -> IDLE on res_ready. Outputs keep their value after the handshake.
// - No back-to-back accept in DONE: start_ready=0 until the block is back in IDLE.
// - flush=1 in any state: go to IDLE next edge, res_valid=0, sum/carry/overflow unchanged.
//   - flush wins over a simultaneous start or res_ready handshake.
// - Reset asserted mid-RUN/DONE: immediate return to reset values; the operation is lost.
// - idx never wraps: it is only advanced in RUN, and the transition to DONE happens at NIBBLES-1.
// - Operands changing after acceptance have no effect (they are latched).
// STRUCTURE
// - Shared package holds:
//   - the state enum {IDLE, RUN, DONE};
//   - the nibble width constant NIB_W=4.
// - One sub-module: bit4adder (existing 4-bit ripple slice).
//   - Instantiated once, combinationally in the nibble loop.
//   - Its bit-3 internal carry is recomputed locally for overflow: a3^b3^s3.
// - Remaining logic lives in this module: FSM, idx counter, operand registers, result register.
// TESTING (WIDTH=16)
// - Add: a=0x1234, b=0x0FFF, c_in=1 -> sum=0x2234, carry=0, overflow=0; res_valid exactly 4 edges after accept.
// - Wrap: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, carry=1, overflow=0.
// - Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, carry=0, overflow=1.
// - Sub: op_sub=1, a=0x0005, b=0x0007, c_in=0 -> sum=0xFFFE, carry=0 (borrow).
// - Backpressure: hold res_ready=0 for 3 cycles in DONE.
//   - sum/res_valid stable; start_ready=0; start_valid pulses ignored.
//   - res_ready=1 -> IDLE next edge.
// - Abort/reset: flush at RUN idx=2 -> IDLE next edge, no res_valid.
//   - rst_n low mid-RUN -> res_valid=0, sum=0 immediately; start_ready=1.
//   - A new add after either abort completes correctly.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_ctrl_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : nibble_serial_adder_ctrl_pkg

// File: rtl/nibble_serial_adder_ctrl_bit4adder.sv
// Combinational 4-bit ripple-carry slice reused once per nibble by the sequencer.
module bit4adder
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum_c,
    output logic             cout_c
);

    logic [NIB_W:0] c;

    always_comb begin
        sum_c = '0;
        c     = '0;
        c[0]  = cin;
        for (int i = 0; i < int'(NIB_W); i++) begin
            sum_c[i] = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout_c = c[NIB_W];

endmodule : bit4adder

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds or subtracts WIDTH-bit operands one nibble per clock through a single
// shared 4-bit ripple slice, with valid/ready handshakes on both sides.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned NIBBLES = WIDTH / NIB_W;
    localparam int unsigned IDX_W   = $clog2(NIBBLES);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q, carry_out_q, ovf_q;

    logic               accept_c, step_c, last_c;
    logic [NIB_W-1:0]   a_nib_c, b_nib_c, slice_sum_c;
    logic               slice_cout_c, msb_carry_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes; flush overrides every handshake
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        accept_c = 1'b1;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    step_c = 1'b1;
                    if (idx_q == IDX_W'(NIBBLES - 1)) begin
                        last_c  = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);

    assign a_nib_c = a_q[idx_q*NIB_W +: NIB_W];
    assign b_nib_c = b_q[idx_q*NIB_W +: NIB_W];

    bit4adder u_slice (
        .a      (a_nib_c),
        .b      (b_nib_c),
        .cin    (carry_q),
        .sum_c  (slice_sum_c),
        .cout_c (slice_cout_c)
    );

    // Carry into the MSB, recovered from the top slice's bit-3 sum
    assign msb_carry_c = a_nib_c[NIB_W-1] ^ b_nib_c[NIB_W-1] ^ slice_sum_c[NIB_W-1];

    // Operand latch, nibble sequencing and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (accept_c) begin
            a_q     <= a_in;
            b_q     <= op_sub ? ~b_in : b_in;
            idx_q   <= '0;
            carry_q <= op_sub ? ~c_in : c_in;
        end else if (step_c) begin
            sum_q[idx_q*NIB_W +: NIB_W] <= slice_sum_c;
            carry_q                     <= slice_cout_c;
            if (last_c) begin
                carry_out_q <= slice_cout_c;
                ovf_q       <= msb_carry_c ^ slice_cout_c;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign sum      = sum_q;
    assign carry    = carry_out_q;
    assign overflow = ovf_q;

endmodule : nibble_serial_adder_ctrl

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: directed vector table, random ops against an arithmetic
// model, plus backpressure, flush and mid-operation reset sequences.
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             start_valid;
    logic             start_ready;
    logic             op_sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    int n_checks = 0;
    int n_errors = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_sub      (op_sub),
        .a_in        (a_in),
        .b_in        (b_in),
        .c_in        (c_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .carry       (carry),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] es;
        logic             ec;
        logic             eo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic void model(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, output logic [WIDTH-1:0] s, output logic c,
                                  output logic o);
        int sa, sb, r;
        logic [WIDTH:0] full;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!op) begin
            full = 17'(a) + 17'(b) + 17'(cin);
            s    = full[WIDTH-1:0];
            c    = full[WIDTH];
            r    = sa + sb + int'(cin);
        end else begin
            s = a - b - 16'(cin);
            c = (32'(a) >= 32'(b) + 32'(cin));
            r = sa - sb - int'(cin);
        end
        o = (r > 32767) || (r < -32768);
    endfunction

    // Starts and ends at posedge+1; checks latency, result and handshake
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        chk({tag, ".start_ready"}, 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        op_sub      = v.op;
        a_in        = v.a;
        b_in        = v.b;
        c_in        = v.cin;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a_in        = 16'($urandom);
        b_in        = 16'($urandom);
        c_in        = 1'($urandom);
        op_sub      = 1'($urandom);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (res_valid) break;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(NIBBLES));
        chk({tag, ".sum"}, 32'(sum), 32'(v.es));
        chk({tag, ".carry"}, 32'(carry), 32'(v.ec));
        chk({tag, ".overflow"}, 32'(overflow), 32'(v.eo));
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, ".res_valid_drop"}, 32'(res_valid), 32'd0);
        chk({tag, ".idle_ready"}, 32'(start_ready), 32'd1);
        chk({tag, ".sum_kept"}, 32'(sum), 32'(v.es));
    endtask

    task automatic accept_only(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start_valid = 1'b1;
        op_sub      = 1'b0;
        a_in        = a;
        b_in        = b;
        c_in        = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    vec_t tbl[6];

    initial begin
        vec_t v;
        tbl[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b1, 16'h2234, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0; flush = 1'b0; start_valid = 1'b0; op_sub = 1'b0;
        a_in = '0; b_in = '0; c_in = 1'b0; res_ready = 1'b0;
        #12;
        chk("reset.start_ready", 32'(start_ready), 32'd1);
        chk("reset.res_valid", 32'(res_valid), 32'd0);
        chk("reset.sum", 32'(sum), 32'd0);
        chk("reset.carry", 32'(carry), 32'd0);
        chk("reset.overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            v.op  = 1'($urandom);
            v.a   = 16'($urandom);
            v.b   = 16'($urandom);
            v.cin = 1'($urandom);
            model(v.op, v.a, v.b, v.cin, v.es, v.ec, v.eo);
            run_op(v, $sformatf("rand%0d", i));
        end

        // Backpressure: result held, new starts ignored while in DONE
        accept_only(16'h1111, 16'h2222);
        repeat (NIBBLES) @(posedge clk);
        #1;
        chk("bp.res_valid_rise", 32'(res_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            start_valid = (k != 1);
            a_in        = 16'h4000 + 16'(k);
            @(posedge clk); #1;
            chk("bp.res_valid_hold", 32'(res_valid), 32'd1);
            chk("bp.start_ready_low", 32'(start_ready), 32'd0);
            chk("bp.sum_hold", 32'(sum), 32'h3333);
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("bp.release_valid", 32'(res_valid), 32'd0);
        chk("bp.release_ready", 32'(start_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp.no_stray_accept", 32'(start_ready), 32'd1);

        // Flush while RUN is on nibble 2
        accept_only(16'hAAAA, 16'h5555);
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush.idle", 32'(start_ready), 32'd1);
        chk("flush.res_valid", 32'(res_valid), 32'd0);
        for (int k = 0; k < NIBBLES; k++) begin
            @(posedge clk); #1;
            chk("flush.no_result", 32'(res_valid), 32'd0);
        end
        run_op(tbl[0], "post_flush");

        // Asynchronous reset mid-RUN
        accept_only(16'hFFFF, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.res_valid", 32'(res_valid), 32'd0);
        chk("arst.sum", 32'(sum), 32'd0);
        chk("arst.carry", 32'(carry), 32'd0);
        chk("arst.start_ready", 32'(start_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(tbl[2], "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_nibble_serial_adder_ctrl
